// File: rtl/dmi_host_bridge.sv
// Host-side sequencer for the core debug port: one command in flight, automatic BUSY retry
// with backoff, response timeout with stale-response drain, one result per command.
module dmi_host_bridge #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 34,
    parameter int MAX_RETRY = 8,
    parameter int BACKOFF   = 16,
    parameter int TIMEOUT   = 1024
) (
    input  logic              uncoreclk,
    input  logic              uncorerst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_resp,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_timeout,
    output logic [7:0]        rsp_tries,
    output logic              io_debug_req_valid,
    input  logic              io_debug_req_ready,
    output logic [ADDR_W-1:0] io_debug_req_bits_addr,
    output logic [1:0]        io_debug_req_bits_op,
    output logic [DATA_W-1:0] io_debug_req_bits_data,
    input  logic              io_debug_resp_valid,
    output logic              io_debug_resp_ready,
    input  logic [1:0]        io_debug_resp_bits_resp,
    input  logic [DATA_W-1:0] io_debug_resp_bits_data,
    output logic              busy
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQ     = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_BACKOFF = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int BO_W  = $clog2(BACKOFF + 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [BO_W-1:0]  BO_LAST   = BO_W'(BACKOFF - 1);
    localparam logic [7:0]       RETRY_LIM = 8'(MAX_RETRY);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        op;
        logic [DATA_W-1:0] data;
    } dbg_req_t;

    logic [2:0]        state;
    dbg_req_t          req_q;
    logic [7:0]        tries;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [BO_W-1:0]   bo_cnt;
    logic              drain;
    logic [1:0]        resp_q;
    logic [DATA_W-1:0] data_q;
    logic              timeout_q;

    logic cmd_fire, req_fire, resp_fire;

    assign cmd_ready           = (state == S_IDLE) && !drain;
    assign io_debug_req_valid  = (state == S_REQ);
    assign io_debug_resp_ready = (state == S_WAIT) || drain;
    assign rsp_valid           = (state == S_DONE);
    assign busy                = (state != S_IDLE);

    assign io_debug_req_bits_addr = req_q.addr;
    assign io_debug_req_bits_op   = req_q.op;
    assign io_debug_req_bits_data = req_q.data;

    assign rsp_resp    = resp_q;
    assign rsp_data    = data_q;
    assign rsp_timeout = timeout_q;
    assign rsp_tries   = tries;

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign req_fire  = io_debug_req_valid && io_debug_req_ready;
    assign resp_fire = io_debug_resp_valid && io_debug_resp_ready;

    always_ff @(posedge uncoreclk or posedge uncorerst) begin
        if (uncorerst) begin
            state     <= S_IDLE;
            req_q     <= '0;
            tries     <= '0;
            tmo_cnt   <= '0;
            bo_cnt    <= '0;
            drain     <= 1'b0;
            resp_q    <= '0;
            data_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            // A stale response after a timeout is swallowed outside WAIT.
            if (drain && resp_fire && state != S_WAIT)
                drain <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_fire) begin
                        req_q <= '{addr: cmd_addr, op: cmd_op, data: cmd_data};
                        tries <= '0;
                        state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (req_fire) begin
                        tries   <= (tries == 8'hFF) ? tries : tries + 8'd1;
                        tmo_cnt <= '0;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A response in the expiry cycle takes priority over the timeout.
                    if (resp_fire) begin
                        if (io_debug_resp_bits_resp == 2'd3 && tries <= RETRY_LIM) begin
                            bo_cnt <= '0;
                            state  <= S_BACKOFF;
                        end else begin
                            resp_q    <= io_debug_resp_bits_resp;
                            data_q    <= io_debug_resp_bits_data;
                            timeout_q <= 1'b0;
                            state     <= S_DONE;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        resp_q    <= 2'd2;
                        data_q    <= '0;
                        timeout_q <= 1'b1;
                        drain     <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_BACKOFF: begin
                    if (bo_cnt == BO_LAST) state <= S_REQ;
                    else                   bo_cnt <= bo_cnt + 1'b1;
                end
                S_DONE: begin
                    if (rsp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmi_host_bridge.sv
// Randomized scoreboard bench for dmi_host_bridge: driver, core model, result monitor and
// handshake-stability monitor run as independent processes.
module tb_dmi_host_bridge;
    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 34;
    localparam int MAX_RETRY = 8;
    localparam int BACKOFF   = 16;
    localparam int TIMEOUT   = 1024;

    logic              uncoreclk, uncorerst;
    logic              cmd_valid, cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [1:0]        cmd_op;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid, rsp_ready;
    logic [1:0]        rsp_resp;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_timeout;
    logic [7:0]        rsp_tries;
    logic              io_debug_req_valid, io_debug_req_ready;
    logic [ADDR_W-1:0] io_debug_req_bits_addr;
    logic [1:0]        io_debug_req_bits_op;
    logic [DATA_W-1:0] io_debug_req_bits_data;
    logic              io_debug_resp_valid, io_debug_resp_ready;
    logic [1:0]        io_debug_resp_bits_resp;
    logic [DATA_W-1:0] io_debug_resp_bits_data;
    logic              busy;

    dmi_host_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_RETRY(MAX_RETRY),
                      .BACKOFF(BACKOFF), .TIMEOUT(TIMEOUT)) dut (
        .uncoreclk(uncoreclk), .uncorerst(uncorerst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp),
        .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .rsp_tries(rsp_tries),
        .io_debug_req_valid(io_debug_req_valid), .io_debug_req_ready(io_debug_req_ready),
        .io_debug_req_bits_addr(io_debug_req_bits_addr), .io_debug_req_bits_op(io_debug_req_bits_op),
        .io_debug_req_bits_data(io_debug_req_bits_data),
        .io_debug_resp_valid(io_debug_resp_valid), .io_debug_resp_ready(io_debug_resp_ready),
        .io_debug_resp_bits_resp(io_debug_resp_bits_resp),
        .io_debug_resp_bits_data(io_debug_resp_bits_data),
        .busy(busy)
    );

    // One entry per debug request the core is expected to see.
    typedef struct {
        int          rdy;
        int          delay;
        bit          silent;
        int          late;
        bit          expect_retry;
        logic [1:0]  resp;
        logic [33:0] data;
    } att_t;

    typedef struct {
        logic [1:0]  resp;
        logic [33:0] data;
        logic        tmo;
        int          tries;
    } exp_t;

    typedef struct {
        logic [4:0]  addr;
        logic [1:0]  op;
        logic [33:0] data;
    } cmd_t;

    att_t att_q[$];
    exp_t exp_q[$];
    cmd_t cur_cmd;
    int   n_cmp = 0;
    int   n_err = 0;
    int   rsp_hold = 0;
    bit   chk_en = 0;

    initial begin
        uncoreclk = 1'b0;
        forever #5 uncoreclk = ~uncoreclk;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ctl"}, {58'd0, cmd_ready, rsp_valid, io_debug_req_valid, io_debug_resp_ready,
                            busy, rsp_timeout}, 64'b100000);
        chk({tag, "_rsp"}, {rsp_resp, rsp_data, rsp_tries}, 64'd0);
        chk({tag, "_req"}, {io_debug_req_bits_addr, io_debug_req_bits_op, io_debug_req_bits_data}, 64'd0);
    endtask

    // kind: 0/1/2 = final core resp code, 3 = core never answers the final request in time.
    task automatic run_cmd(input logic [4:0] addr, input logic [1:0] op, input logic [33:0] data,
                           input int nb, input int kind, input logic [33:0] fdata,
                           input int rdy0, input int dly0, input int hold);
        att_t a;
        exp_t e;
        int   total;
        int   n;
        total = (nb > MAX_RETRY) ? MAX_RETRY + 1 : nb + 1;
        for (int i = 0; i < total; i++) begin
            a.rdy          = (i == 0) ? rdy0 : int'($urandom_range(0, 3));
            a.delay        = (i == 0 && dly0 >= 0) ? dly0 : int'($urandom_range(0, 5));
            a.silent       = 1'b0;
            a.late         = 0;
            a.expect_retry = (i < total - 1);
            if (i < nb) begin
                a.resp = 2'd3;
                a.data = {2'($urandom_range(0, 3)), $urandom()};
            end else if (kind == 3) begin
                a.silent = 1'b1;
                a.late   = $urandom_range(5, 20);
                a.resp   = 2'd0;
                a.data   = '0;
            end else begin
                a.resp = 2'(kind);
                a.data = fdata;
            end
            att_q.push_back(a);
        end
        e.tries = total;
        e.tmo   = (kind == 3) && (nb <= MAX_RETRY);
        e.resp  = e.tmo ? 2'd2 : a.resp;
        e.data  = e.tmo ? 34'd0 : a.data;
        exp_q.push_back(e);
        rsp_hold = hold;

        n = 0;
        @(negedge uncoreclk);
        while (!cmd_ready && n < 3000) begin
            @(negedge uncoreclk);
            n++;
        end
        chk("cmd_ready_wait", {63'd0, cmd_ready}, 64'd1);
        cur_cmd   = '{addr: addr, op: op, data: data};
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_op    = op;
        cmd_data  = data;
        @(negedge uncoreclk);
        cmd_valid = 1'b0;
        cmd_data  = {2'($urandom_range(0, 3)), $urandom()};
        chk("req_after_cmd", {63'd0, io_debug_req_valid}, 64'd1);

        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge uncoreclk);
            n++;
        end
        chk("rsp_done", 64'(exp_q.size()), 64'd0);
        if (exp_q.size() != 0) begin
            exp_q.delete();
            att_q.delete();
        end
    endtask

    initial begin : core_model
        att_t a;
        int   n;
        io_debug_req_ready      = 1'b0;
        io_debug_resp_valid     = 1'b0;
        io_debug_resp_bits_resp = '0;
        io_debug_resp_bits_data = '0;
        forever begin
            @(negedge uncoreclk);
            if (io_debug_req_valid && !uncorerst) begin
                if (att_q.size() == 0) begin
                    chk("extra_req", 64'd1, 64'd0);
                    a = '{rdy: 0, delay: 0, silent: 1'b0, late: 0, expect_retry: 1'b0,
                          resp: 2'd0, data: 34'd0};
                end else begin
                    a = att_q.pop_front();
                end
                repeat (a.rdy) @(negedge uncoreclk);
                io_debug_req_ready = 1'b1;
                chk("req_fields", {23'd0, io_debug_req_valid, io_debug_req_bits_addr,
                                   io_debug_req_bits_op, io_debug_req_bits_data},
                    {23'd0, 1'b1, cur_cmd.addr, cur_cmd.op, cur_cmd.data});
                @(negedge uncoreclk);
                io_debug_req_ready = 1'b0;
                if (a.silent) begin
                    if (a.late >= 0) begin
                        n = 0;
                        while (!rsp_valid && n < 3000) begin
                            n++;
                            @(negedge uncoreclk);
                        end
                        chk("timeout_latency", 64'(n), 64'(TIMEOUT));
                        n = 0;
                        repeat (a.late) begin
                            @(negedge uncoreclk);
                            if (cmd_ready) n++;
                        end
                        chk("cmd_ready_in_drain", 64'(n), 64'd0);
                        io_debug_resp_valid     = 1'b1;
                        io_debug_resp_bits_resp = 2'($urandom_range(0, 3));
                        io_debug_resp_bits_data = {2'($urandom_range(0, 3)), $urandom()};
                        chk("drain_resp_ready", {63'd0, io_debug_resp_ready}, 64'd1);
                        @(negedge uncoreclk);
                        io_debug_resp_valid = 1'b0;
                    end
                end else begin
                    repeat (a.delay) @(negedge uncoreclk);
                    io_debug_resp_valid     = 1'b1;
                    io_debug_resp_bits_resp = a.resp;
                    io_debug_resp_bits_data = a.data;
                    chk("resp_ready", {63'd0, io_debug_resp_ready}, 64'd1);
                    @(negedge uncoreclk);
                    io_debug_resp_valid = 1'b0;
                    if (a.expect_retry) begin
                        n = 0;
                        while (!io_debug_req_valid && n < 200) begin
                            n++;
                            @(negedge uncoreclk);
                        end
                        chk("backoff_gap", 64'(n), 64'(BACKOFF));
                    end
                end
            end
        end
    end

    initial begin : rsp_monitor
        exp_t e;
        rsp_ready = 1'b0;
        forever begin
            @(negedge uncoreclk);
            if (rsp_hold > 0 && rsp_valid) begin
                rsp_ready = 1'b0;
                rsp_hold--;
            end else begin
                rsp_ready = ($urandom_range(0, 3) != 0);
            end
            if (rsp_valid && rsp_ready && !uncorerst) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_resp", 64'(rsp_resp), 64'(e.resp));
                    chk("rsp_data", 64'(rsp_data), 64'(e.data));
                    chk("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
                    chk("rsp_tries", 64'(rsp_tries), 64'(e.tries));
                end
            end
        end
    end

    // While a handshake is stalled, the offered payload must not move.
    initial begin : stability
        logic        rq_hold, rs_hold;
        logic [63:0] rq_save, rs_save;
        rq_hold = 1'b0;
        rs_hold = 1'b0;
        rq_save = '0;
        rs_save = '0;
        forever begin
            @(negedge uncoreclk);
            #1;
            if (chk_en && rq_hold)
                chk("req_stable", {22'd0, io_debug_req_valid, io_debug_req_bits_addr,
                                   io_debug_req_bits_op, io_debug_req_bits_data}, rq_save);
            if (chk_en && rs_hold)
                chk("rsp_stable", {18'd0, rsp_valid, rsp_resp, rsp_data, rsp_timeout, rsp_tries}, rs_save);
            rq_hold = io_debug_req_valid && !io_debug_req_ready;
            rs_hold = rsp_valid && !rsp_ready;
            rq_save = {22'd0, io_debug_req_valid, io_debug_req_bits_addr,
                       io_debug_req_bits_op, io_debug_req_bits_data};
            rs_save = {18'd0, rsp_valid, rsp_resp, rsp_data, rsp_timeout, rsp_tries};
        end
    end

    initial begin : driver
        int nb, kind, n;
        uncorerst = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_op    = '0;
        cmd_data  = '0;
        #1;
        check_reset_vals("reset");
        repeat (3) @(negedge uncoreclk);
        uncorerst = 1'b0;
        chk_en    = 1'b1;

        run_cmd(5'h10, 2'd2, 34'h3_0000_0001, 0, 0, 34'h0_1234_5678, 0, 3, 0);
        run_cmd(5'h11, 2'd1, 34'h0, 2, 0, 34'h2A, 0, -1, 0);
        run_cmd(5'h12, 2'd1, 34'h0, 100, 0, 34'h0, 0, -1, 0);
        repeat (BACKOFF + 4) @(negedge uncoreclk);
        run_cmd(5'h13, 2'd1, 34'h0, 0, 3, 34'h0, 0, -1, 0);
        run_cmd(5'h14, 2'd2, 34'h1_5555_AAAA, 0, 0, 34'h2_DEAD_BEEF, 0, -1, 0);
        run_cmd(5'h15, 2'd2, 34'h2_AAAA_5555, 1, 2, 34'h1_0F0F_0F0F, 20, -1, 5);

        for (int i = 0; i < 40; i++) begin
            n    = $urandom_range(0, 19);
            nb   = (n < 12) ? 0 : (n < 18) ? int'($urandom_range(1, 3)) : int'($urandom_range(8, 12));
            kind = ($urandom_range(0, 14) == 0) ? 3 : int'($urandom_range(0, 2));
            run_cmd(5'($urandom()), 2'($urandom()), {2'($urandom_range(0, 3)), $urandom()},
                    nb, kind, {2'($urandom_range(0, 3)), $urandom()},
                    $urandom_range(0, 4), -1, $urandom_range(0, 3));
        end

        // Reset while the bridge waits on a core that never answers.
        att_q.push_back('{rdy: 0, delay: 0, silent: 1'b1, late: -1, expect_retry: 1'b0,
                          resp: 2'd0, data: 34'd0});
        n = 0;
        @(negedge uncoreclk);
        while (!cmd_ready && n < 3000) begin
            @(negedge uncoreclk);
            n++;
        end
        cur_cmd   = '{addr: 5'h1F, op: 2'd1, data: 34'h0};
        cmd_addr  = 5'h1F;
        cmd_op    = 2'd1;
        cmd_data  = '0;
        cmd_valid = 1'b1;
        @(negedge uncoreclk);
        cmd_valid = 1'b0;
        n = 0;
        while (!(io_debug_resp_ready && busy) && n < 100) begin
            @(negedge uncoreclk);
            n++;
        end
        chk("wait_state_reached", {62'd0, io_debug_resp_ready, busy}, 64'b11);
        repeat (5) @(negedge uncoreclk);
        chk_en = 1'b0;
        #2;
        uncorerst = 1'b1;
        #1;
        check_reset_vals("midrst");
        repeat (2) @(negedge uncoreclk);
        uncorerst = 1'b0;
        repeat (2) @(negedge uncoreclk);
        chk("post_rst_idle", {62'd0, cmd_ready, busy}, 64'b10);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
